// File: rtl/spi_flash_pkg.sv
// Shared SPI flash controller definitions: request/data FSM state encodings, opcodes and bit-length helper.
package spi_flash_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EX_REQ   = 2'd1,
        REQ_EXEC = 2'd2,
        REQ_FSH  = 2'd3
    } req_state_t;

    typedef enum logic [2:0] {
        DIDLE      = 3'd0,
        SEND_CMD   = 3'd1,
        SEND_ADDR2 = 3'd2,
        SEND_ADDR1 = 3'd3,
        SEND_ADDR0 = 3'd4,
        SEND_DUMMY = 3'd5,
        RECV_DATA  = 3'd6,
        RECV_FSH   = 3'd7
    } data_state_t;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_PAGE_PRG  = 8'h02;

    localparam int unsigned LEN_W = 24;

    // Bit count on the SPI lanes for a number of bytes.
    function automatic logic [LEN_W-1:0] bits_len(input int unsigned bytes, input int unsigned ssize);
        return LEN_W'((bytes * 32'd8) / ssize);
    endfunction

endpackage

// File: rtl/flash_rd_fifo.sv
// Synchronous FIFO with a registered head: rd_data/rd_valid present the oldest entry.
module flash_rd_fifo #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [DSIZE-1:0] wr_data,
    input  logic             rd_en,
    output logic [DSIZE-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DSIZE-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    rptr_nxt;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             wr_ok;
    logic             rd_ok;

    // A write while full is only taken when a read frees a slot in the same cycle.
    always_comb begin
        rd_ok     = rd_en && rd_valid;
        wr_ok     = wr_en && (!full || rd_ok);
        rptr_nxt  = rd_ok ? AW'(rptr + 1'b1) : rptr;
        count_nxt = count + CW'(wr_ok) - CW'(rd_ok);
    end

    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= AW'(wptr + 1'b1);
            end
            rptr     <= rptr_nxt;
            count    <= count_nxt;
            full     <= (count_nxt == CW'(DEPTH));
            empty    <= (count_nxt == '0);
            rd_valid <= (count_nxt != '0);
            // Head register bypasses the write when the new entry becomes the head.
            if (count_nxt != '0) begin
                rd_data <= (wr_ok && (wptr == rptr_nxt)) ? wr_data : mem[rptr_nxt];
            end
        end
    end

endmodule

// File: rtl/read_flash_burst.sv
// SPI flash burst reader: sends READ + 24-bit address, streams BURST_LEN received bytes through a FIFO.
// Define READ_FLASH_BURST_FAST_READ_EN for FAST_READ (0x0B) with one dummy byte after the address.
module read_flash_burst
    import spi_flash_pkg::*;
#(
    parameter int unsigned DSIZE      = 8,
    parameter int unsigned SSIZE      = 1,
    parameter int unsigned BURST_LEN  = 256,
    parameter logic [7:0]  READ_CMD   = OP_READ,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic [23:0]      start_addr,
    output logic             busy,
    output logic             finish,
    output logic             overflow,
    output logic             spi_request,
    output logic [23:0]      spi_req_len,
    output logic [23:0]      spi_req_wr_len,
    input  logic             spi_busy,
    input  logic             spi_clk_en,
    input  logic             spi_wr_ready,
    output logic             spi_wr_vld,
    output logic [DSIZE-1:0] spi_wr_data,
    input  logic             spi_rd_vld,
    input  logic [DSIZE-1:0] spi_rd_data,
    output logic             out_valid,
    output logic [DSIZE-1:0] out_data,
    input  logic             out_ready
);

    localparam int unsigned CNT_W = 9;

`ifdef READ_FLASH_BURST_FAST_READ_EN
    localparam logic [7:0]  OPCODE     = OP_FAST_READ;
    localparam int unsigned WR_BYTES   = 5;
    localparam data_state_t AFTER_ADDR = SEND_DUMMY;
`else
    localparam logic [7:0]  OPCODE     = READ_CMD;
    localparam int unsigned WR_BYTES   = 4;
    localparam data_state_t AFTER_ADDR = RECV_DATA;
`endif

    req_state_t       req_state;
    req_state_t       req_next;
    data_state_t      data_state;
    data_state_t      data_next;
    logic [23:0]      addr;
    logic [CNT_W-1:0] byte_cnt;
    logic             start_ok;
    logic             req_exit;
    logic             wr_adv;
    logic             sending;
    logic [7:0]       wr_byte;
    logic             rd_take;
    logic             fifo_rd;
    logic             fifo_full;
    logic             fifo_empty;

    assign spi_req_len    = bits_len(BURST_LEN + WR_BYTES, SSIZE);
    assign spi_req_wr_len = bits_len(WR_BYTES, SSIZE);

    assign rd_take = (data_state == RECV_DATA) && spi_rd_vld && (byte_cnt < CNT_W'(BURST_LEN));
    assign fifo_rd = out_valid && out_ready;

    // Request FSM: waits for the SPI master to take and complete the request, then for the FIFO to drain.
    always_comb begin
        req_next = req_state;
        start_ok = 1'b0;
        case (req_state)
            IDLE: begin
                if (start) begin
                    req_next = EX_REQ;
                    start_ok = 1'b1;
                end
            end
            EX_REQ:   if (spi_busy) req_next = REQ_EXEC;
            REQ_EXEC: if (!spi_busy && fifo_empty && !rd_take) req_next = REQ_FSH;
            REQ_FSH:  req_next = IDLE;
            default:  req_next = IDLE;
        endcase
        req_exit = (req_state == REQ_EXEC) && (req_next != REQ_EXEC);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            req_state   <= IDLE;
            spi_request <= 1'b0;
            busy        <= 1'b0;
            finish      <= 1'b0;
            addr        <= '0;
        end else begin
            req_state   <= req_next;
            spi_request <= (req_next == EX_REQ);
            busy        <= (req_next == EX_REQ) || (req_next == REQ_EXEC);
            finish      <= (req_next == REQ_FSH);
            if (start_ok) begin
                addr <= start_addr;
            end
        end
    end

    // Data FSM: one command/address byte per accepted SPI byte slot, then receive until the request ends.
    always_comb begin
        data_next = data_state;
        wr_adv    = spi_wr_ready && spi_clk_en;
        case (data_state)
            DIDLE:      if (start_ok) data_next = SEND_CMD;
            SEND_CMD:   if (wr_adv) data_next = SEND_ADDR2;
            SEND_ADDR2: if (wr_adv) data_next = SEND_ADDR1;
            SEND_ADDR1: if (wr_adv) data_next = SEND_ADDR0;
            SEND_ADDR0: if (wr_adv) data_next = AFTER_ADDR;
            SEND_DUMMY: if (wr_adv) data_next = RECV_DATA;
            RECV_DATA:  data_next = RECV_DATA;
            RECV_FSH:   data_next = DIDLE;
            default:    data_next = DIDLE;
        endcase
        if (req_exit && (data_state != DIDLE) && (data_state != RECV_FSH)) begin
            data_next = RECV_FSH;
        end

        sending = 1'b0;
        wr_byte = 8'h00;
        case (data_next)
            SEND_CMD:   begin sending = 1'b1; wr_byte = OPCODE;       end
            SEND_ADDR2: begin sending = 1'b1; wr_byte = addr[23:16];  end
            SEND_ADDR1: begin sending = 1'b1; wr_byte = addr[15:8];   end
            SEND_ADDR0: begin sending = 1'b1; wr_byte = addr[7:0];    end
            SEND_DUMMY: begin sending = 1'b1; wr_byte = 8'h00;        end
            default:    begin sending = 1'b0; wr_byte = 8'h00;        end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            data_state  <= DIDLE;
            spi_wr_vld  <= 1'b0;
            spi_wr_data <= '0;
            byte_cnt    <= '0;
            overflow    <= 1'b0;
        end else begin
            data_state  <= data_next;
            spi_wr_vld  <= sending;
            spi_wr_data <= DSIZE'(wr_byte);
            if (start_ok) begin
                byte_cnt <= '0;
            end else if (rd_take) begin
                byte_cnt <= CNT_W'(byte_cnt + 1'b1);
            end
            if (start_ok) begin
                overflow <= 1'b0;
            end else if (rd_take && fifo_full && !fifo_rd) begin
                overflow <= 1'b1;
            end
        end
    end

    flash_rd_fifo #(
        .DSIZE (DSIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .rst_n    (rst_n),
        .wr_en    (rd_take),
        .wr_data  (spi_rd_data),
        .rd_en    (fifo_rd),
        .rd_data  (out_data),
        .rd_valid (out_valid),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_read_flash_burst.sv
// Directed bench for read_flash_burst: command bytes, full bursts, FIFO overflow, extra strobes, mid-burst reset.
`timescale 1ns/1ps
module tb_read_flash_burst;

`ifdef READ_FLASH_BURST_FAST_READ_EN
    localparam int          WR_N       = 5;
    localparam logic [23:0] LEN_EXP    = 24'd2088;
    localparam logic [23:0] WR_LEN_EXP = 24'd40;
`else
    localparam int          WR_N       = 4;
    localparam logic [23:0] LEN_EXP    = 24'd2080;
    localparam logic [23:0] WR_LEN_EXP = 24'd32;
`endif

    logic        clock;
    logic        rst_n;
    logic        start;
    logic [23:0] start_addr;
    logic        busy;
    logic        finish;
    logic        overflow;
    logic        spi_request;
    logic [23:0] spi_req_len;
    logic [23:0] spi_req_wr_len;
    logic        spi_busy;
    logic        spi_clk_en;
    logic        spi_wr_ready;
    logic        spi_wr_vld;
    logic [7:0]  spi_wr_data;
    logic        spi_rd_vld;
    logic [7:0]  spi_rd_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    int         checks;
    int         errors;
    logic [7:0] wb [5];
    logic [7:0] rx_q [$];
    int         fin_cnt;
    int         ovf_at;
    int         rx_at_fin;
    int         stab_err;
    bit         timed_out;

    read_flash_burst dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .start          (start),
        .start_addr     (start_addr),
        .busy           (busy),
        .finish         (finish),
        .overflow       (overflow),
        .spi_request    (spi_request),
        .spi_req_len    (spi_req_len),
        .spi_req_wr_len (spi_req_wr_len),
        .spi_busy       (spi_busy),
        .spi_clk_en     (spi_clk_en),
        .spi_wr_ready   (spi_wr_ready),
        .spi_wr_vld     (spi_wr_vld),
        .spi_wr_data    (spi_wr_data),
        .spi_rd_vld     (spi_rd_vld),
        .spi_rd_data    (spi_rd_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SPI master model for the command phase: byte slots every other cycle, bytes captured per handshake.
    task automatic do_cmd(input logic [23:0] a, output int nb, output bit req_ok);
        @(negedge clock);
        start      = 1'b1;
        start_addr = a;
        @(negedge clock);
        start  = 1'b0;
        req_ok = spi_request && busy;
        spi_busy = 1'b1;
        @(negedge clock);
        spi_wr_ready = 1'b1;
        nb = 0;
        for (int c = 0; c < 64 && nb < WR_N; c++) begin
            spi_clk_en = c[0];
            if (spi_wr_vld && spi_clk_en && nb < 5) begin
                wb[nb] = spi_wr_data;
                nb++;
            end
            @(negedge clock);
        end
        spi_clk_en   = 1'b0;
        spi_wr_ready = 1'b0;
    endtask

    // Receive phase model: n strobes of 0,1,2..; downstream either always ready or held off until strobes end.
    task automatic run_burst(input int n, input bit hold);
        int         sent      = 0;
        int         extra     = 0;
        bit         prev_hold = 1'b0;
        logic [7:0] prev_data = 8'h00;
        rx_q.delete();
        fin_cnt   = 0;
        ovf_at    = 0;
        rx_at_fin = -1;
        stab_err  = 0;
        timed_out = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            if (finish) begin
                fin_cnt++;
                rx_at_fin = rx_q.size();
            end
            if (overflow && ovf_at == 0) ovf_at = sent;
            if (prev_hold && out_valid && out_data !== prev_data) stab_err++;
            out_ready = !(hold && sent < n);
            if (out_valid && out_ready) rx_q.push_back(out_data);
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            if (sent < n) begin
                spi_rd_vld  = 1'b1;
                spi_rd_data = 8'(sent);
                sent++;
            end else begin
                spi_rd_vld = 1'b0;
                spi_busy   = 1'b0;
            end
            if (fin_cnt > 0) begin
                extra++;
                if (extra > 3) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
        spi_rd_vld = 1'b0;
        out_ready  = 1'b0;
        spi_busy   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, finish, overflow, spi_request, spi_wr_vld, spi_wr_data, out_valid, out_data} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b fin=%b ovf=%b req=%b wvld=%b wdata=%h oval=%h odata=%h, want all 0",
                     busy, finish, overflow, spi_request, spi_wr_vld, spi_wr_data, out_valid, out_data);
        end
        checks++;
        if (spi_req_len !== LEN_EXP) begin
            errors++;
            $display("FAIL req_len: got %0d want %0d", spi_req_len, LEN_EXP);
        end
        checks++;
        if (spi_req_wr_len !== WR_LEN_EXP) begin
            errors++;
            $display("FAIL req_wr_len: got %0d want %0d", spi_req_wr_len, WR_LEN_EXP);
        end
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_cmd_phase();
        int         nb;
        bit         req_ok;
        logic [7:0] exp [5];
        logic [23:0] a;
`ifdef READ_FLASH_BURST_FAST_READ_EN
        a   = 24'h000100;
        exp = '{8'h0B, 8'h00, 8'h01, 8'h00, 8'h00};
`else
        a   = 24'h012345;
        exp = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00};
`endif
        do_cmd(a, nb, req_ok);
        checks++;
        if (req_ok !== 1'b1) begin
            errors++;
            $display("FAIL start_request: got spi_request&busy=%b want 1", req_ok);
        end
        checks++;
        if (nb != WR_N) begin
            errors++;
            $display("FAIL cmd_byte_count: got %0d want %0d", nb, WR_N);
        end
        for (int i = 0; i < WR_N; i++) begin
            checks++;
            if (wb[i] !== exp[i]) begin
                errors++;
                $display("FAIL cmd_byte[%0d]: got %h want %h", i, wb[i], exp[i]);
            end
        end
        checks++;
        if (spi_wr_vld !== 1'b0 || spi_request !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL after_cmd: got wvld=%b req=%b busy=%b want 0 0 1", spi_wr_vld, spi_request, busy);
        end
    endtask

    task automatic test_start_ignored();
        @(negedge clock);
        start      = 1'b1;
        start_addr = 24'hFFFFFF;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (spi_request !== 1'b0 || spi_wr_vld !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_while_busy: got req=%b wvld=%b busy=%b want 0 0 1", spi_request, spi_wr_vld, busy);
        end
    endtask

    task automatic test_full_burst();
        int bad = 0;
        run_burst(256, 1'b0);
        checks++;
        if (timed_out || fin_cnt != 1) begin
            errors++;
            $display("FAIL full_finish: got %0d pulses timeout=%0d want 1 pulse", fin_cnt, timed_out);
        end
        checks++;
        if (rx_q.size() != 256) begin
            errors++;
            $display("FAIL full_count: got %0d bytes want 256", rx_q.size());
        end
        for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== 8'(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_data: got %0d wrong bytes want 0", bad);
        end
        checks++;
        if (rx_at_fin != 256 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_end: got bytes_at_finish=%0d ovf=%b want 256 0", rx_at_fin, overflow);
        end
    endtask

    task automatic test_hold();
        int nb;
        bit req_ok;
        int bad = 0;
        do_cmd(24'h123456, nb, req_ok);
        checks++;
        if (nb != WR_N || !req_ok) begin
            errors++;
            $display("FAIL hold_cmd: got %0d bytes req=%0d want %0d 1", nb, req_ok, WR_N);
        end
        run_burst(256, 1'b1);
        checks++;
        if (ovf_at != 17) begin
            errors++;
            $display("FAIL hold_ovf_strobe: got %0d want 17", ovf_at);
        end
        checks++;
        if (rx_q.size() != 16) begin
            errors++;
            $display("FAIL hold_count: got %0d want 16", rx_q.size());
        end
        for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== 8'(i)) bad++;
        checks++;
        if (bad != 0 || stab_err != 0) begin
            errors++;
            $display("FAIL hold_data: got %0d wrong %0d unstable want 0 0", bad, stab_err);
        end
        checks++;
        if (timed_out || fin_cnt != 1 || rx_at_fin != 16) begin
            errors++;
            $display("FAIL hold_finish: got pulses=%0d at_bytes=%0d timeout=%0d want 1 16 0", fin_cnt, rx_at_fin, timed_out);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL hold_sticky: got ovf=%b want 1", overflow);
        end
    endtask

    task automatic test_extra_strobes();
        int nb;
        bit req_ok;
        int bad = 0;
        do_cmd(24'h000000, nb, req_ok);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear_on_start: got %b want 0", overflow);
        end
        run_burst(260, 1'b0);
        checks++;
        if (rx_q.size() != 256) begin
            errors++;
            $display("FAIL extra_count: got %0d want 256", rx_q.size());
        end
        for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== 8'(i)) bad++;
        checks++;
        if (bad != 0 || timed_out || fin_cnt != 1) begin
            errors++;
            $display("FAIL extra_data: got %0d wrong pulses=%0d timeout=%0d want 0 1 0", bad, fin_cnt, timed_out);
        end
    endtask

    task automatic test_reset_mid();
        int nb;
        bit req_ok;
        int bad = 0;
        do_cmd(24'h00ABCD, nb, req_ok);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            spi_rd_vld  = 1'b1;
            spi_rd_data = 8'(8'hA0 + i);
        end
        @(negedge clock);
        spi_rd_vld = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA0) begin
            errors++;
            $display("FAIL mid_head: got valid=%b data=%h want 1 a0", out_valid, out_data);
        end
        rst_n = 1'b0;
        spi_busy = 1'b0;
        #1;
        checks++;
        if ({busy, finish, overflow, spi_request, spi_wr_vld, spi_wr_data, out_valid, out_data} !== 22'd0) begin
            errors++;
            $display("FAIL mid_reset_async: got busy=%b fin=%b ovf=%b req=%b wvld=%b oval=%b odata=%h want all 0",
                     busy, finish, overflow, spi_request, spi_wr_vld, out_valid, out_data);
        end
        @(posedge clock);
        #1;
        checks++;
        if ({busy, finish, overflow, spi_request, spi_wr_vld, spi_wr_data, out_valid, out_data} !== 22'd0) begin
            errors++;
            $display("FAIL mid_reset_edge: got busy=%b req=%b wvld=%b oval=%b want all 0", busy, spi_request, spi_wr_vld, out_valid);
        end
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        do_cmd(24'h00FFEE, nb, req_ok);
        checks++;
        if (nb != WR_N || !req_ok || wb[1] !== 8'h00 || wb[2] !== 8'hFF || wb[3] !== 8'hEE) begin
            errors++;
            $display("FAIL post_reset_cmd: got n=%0d req=%0d bytes %h %h %h want %0d 1 00 ff ee",
                     nb, req_ok, wb[1], wb[2], wb[3], WR_N);
        end
        run_burst(256, 1'b0);
        for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== 8'(i)) bad++;
        checks++;
        if (rx_q.size() != 256 || bad != 0 || fin_cnt != 1 || timed_out) begin
            errors++;
            $display("FAIL post_reset_burst: got n=%0d wrong=%0d pulses=%0d timeout=%0d want 256 0 1 0",
                     rx_q.size(), bad, fin_cnt, timed_out);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        start_addr   = 24'h0;
        spi_busy     = 1'b0;
        spi_clk_en   = 1'b0;
        spi_wr_ready = 1'b0;
        spi_rd_vld   = 1'b0;
        spi_rd_data  = 8'h00;
        out_ready    = 1'b0;
        test_reset();
        test_cmd_phase();
        test_start_ignored();
        test_full_burst();
        test_hold();
        test_extra_strobes();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
